// File: rtl/exu_muldiv.sv
// Multi-cycle RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, with a one-cycle path for divide-by-zero and signed overflow.
module exu_muldiv #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    counter;
    logic [XLEN-1:0]  acc_hi;
    logic [XLEN-1:0]  acc_lo;
    logic [XLEN-1:0]  opb;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
    logic             neg;
    logic             fast;

    logic             is_div;
    logic             sgn1;
    logic             sgn2;
    logic             div_zero;
    logic             ovf;
    logic             fast_in;
    logic             neg_in;
    logic [XLEN-1:0]  mag1;
    logic [XLEN-1:0]  mag2;
    logic [XLEN-1:0]  fast_res;
    logic [XLEN-1:0]  min_val;

    assign min_val  = {1'b1, {(XLEN-1){1'b0}}};
    assign in_ready = (state == IDLE) && !flush;
    assign busy     = (state != IDLE);

    always_comb begin
        is_div   = in_op[2];
        sgn1     = in_rs1[XLEN-1] &&
                   ((in_op == OP_MULH) || (in_op == OP_MULHSU) ||
                    (in_op == OP_DIV)  || (in_op == OP_REM));
        sgn2     = in_rs2[XLEN-1] &&
                   ((in_op == OP_MULH) || (in_op == OP_DIV) ||
                    (in_op == OP_REM));
        mag1     = sgn1 ? -in_rs1 : in_rs1;
        mag2     = sgn2 ? -in_rs2 : in_rs2;
        div_zero = is_div && (in_rs2 == '0);
        ovf      = ((in_op == OP_DIV) || (in_op == OP_REM)) &&
                   (in_rs1 == min_val) && (&in_rs2);
        fast_in  = div_zero || ovf;
        // Remainder follows the dividend sign; everything else is sign1^sign2.
        neg_in   = (in_op == OP_REM) ? sgn1 : (sgn1 ^ sgn2);
        fast_res = '0;
        if (div_zero) begin
            fast_res = in_op[1] ? in_rs1 : '1;
        end else if (ovf) begin
            fast_res = in_op[1] ? '0 : in_rs1;
        end
    end

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;
    logic [XLEN-1:0] nxt_hi;
    logic [XLEN-1:0] nxt_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opb};
        div_diff  = div_shift[XLEN-1:0] - opb;
        if (op[2]) begin
            nxt_hi = div_ge ? div_diff : div_shift[XLEN-1:0];
            nxt_lo = {acc_lo[XLEN-2:0], div_ge};
        end else begin
            nxt_hi = mul_sum[XLEN:1];
            nxt_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   fin;

    always_comb begin
        prod   = {acc_hi, acc_lo};
        prod_s = neg ? -prod : prod;
        quot_s = neg ? -acc_lo : acc_lo;
        rem_s  = neg ? -acc_hi : acc_hi;
        fin    = '0;
        if (fast) begin
            fin = acc_lo;
        end else begin
            case (op)
                OP_MUL:    fin = prod_s[XLEN-1:0];
                OP_MULH,
                OP_MULHSU,
                OP_MULHU:  fin = prod_s[2*XLEN-1:XLEN];
                OP_DIV,
                OP_DIVU:   fin = quot_s;
                default:   fin = rem_s;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            opb        <= '0;
            op         <= '0;
            tag        <= '0;
            neg        <= 1'b0;
            fast       <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            state     <= IDLE;
            counter   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op      <= in_op;
                        tag     <= in_tag;
                        neg     <= neg_in;
                        fast    <= fast_in;
                        acc_hi  <= '0;
                        opb     <= is_div ? mag2 : mag1;
                        // Fast ops park their result in acc_lo and finish next edge.
                        if (fast_in) begin
                            acc_lo  <= fast_res;
                            counter <= '0;
                        end else begin
                            acc_lo  <= is_div ? mag1 : mag2;
                            counter <= CW'(XLEN);
                        end
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (counter == '0) begin
                        out_result <= fin;
                        out_tag    <= tag;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        acc_hi  <= nxt_hi;
                        acc_lo  <= nxt_lo;
                        counter <= counter - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exu_muldiv.sv
// Directed bench for exu_muldiv: XLEN=32 instance for the main cases and
// an XLEN=16 instance for width scaling.
module tb_exu_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    logic        h_in_valid = 1'b0;
    logic        h_in_ready;
    logic [2:0]  h_in_op = '0;
    logic [15:0] h_in_rs1 = '0;
    logic [15:0] h_in_rs2 = '0;
    logic [4:0]  h_in_tag = '0;
    logic        h_out_valid;
    logic        h_out_ready = 1'b1;
    logic [15:0] h_out_result;
    logic [4:0]  h_out_tag;
    logic        h_busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    exu_muldiv #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .busy(busy)
    );

    exu_muldiv #(.XLEN(16), .TAG_W(5)) dut16 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(h_in_valid), .in_ready(h_in_ready), .in_op(h_in_op),
        .in_rs1(h_in_rs1), .in_rs2(h_in_rs2), .in_tag(h_in_tag),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .out_result(h_out_result), .out_tag(h_out_tag), .busy(h_busy)
    );

    task automatic start32(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_rs1 = 32'hDEADBEEF; in_rs2 = 32'h0BADF00D; in_op = 3'd7;
    endtask

    task automatic wait32(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_op32(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag,
                           output int lat, output logic [31:0] res,
                           output logic [4:0] rtag);
        out_ready = 1'b1;
        start32(op, a, b, tag);
        wait32(lat);
        res = out_result;
        rtag = out_tag;
        @(posedge clk); #1;
    endtask

    task automatic do_op16(input logic [2:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [4:0] tag,
                           output int lat, output logic [15:0] res,
                           output logic [4:0] rtag);
        int n = 0;
        h_out_ready = 1'b1;
        while (!h_in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        h_in_op = op; h_in_rs1 = a; h_in_rs2 = b; h_in_tag = tag;
        h_in_valid = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (h_out_valid) begin
                lat = i;
                break;
            end
        end
        res = h_out_result;
        rtag = h_out_tag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags valid=%b busy=%b want 0 0", out_valid, busy);
        end
        total++;
        if (out_result !== 32'h0 || out_tag !== 5'h0) begin
            bad++;
            $display("FAIL reset_data result=%h tag=%h want 0 0", out_result, out_tag);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || h_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b/%b want 1/1", in_ready, h_in_ready);
        end
    endtask

    task automatic test_mul();
        int lat;
        logic [31:0] res;
        logic [4:0] t;
        do_op32(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, lat, res, t);
        total++;
        if (lat != 33) begin
            bad++;
            $display("FAIL mul_latency got=%0d want=33", lat);
        end
        total++;
        if (res !== 32'hFFFFFFEB) begin
            bad++;
            $display("FAIL mul_result got=%h want=ffffffeb", res);
        end
        total++;
        if (t !== 5'd5) begin
            bad++;
            $display("FAIL mul_tag got=%0d want=5", t);
        end
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mul_idle busy=%b valid=%b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_mulh();
        logic [2:0]  ops [3];
        logic [31:0] exp [3];
        int lat;
        logic [31:0] res;
        logic [4:0] t;
        ops = '{3'd1, 3'd2, 3'd3};
        exp = '{32'h00000000, 32'h80000000, 32'h7FFFFFFF};
        for (int i = 0; i < 3; i++) begin
            do_op32(ops[i], 32'h80000000, 32'hFFFFFFFF, 5'(i + 10), lat, res, t);
            total++;
            if (res !== exp[i] || lat != 33) begin
                bad++;
                $display("FAIL mulh_op%0d result=%h lat=%0d want=%h lat=33",
                         ops[i], res, lat, exp[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [4];
        logic [31:0] a [4];
        logic [31:0] b [4];
        logic [31:0] exp [4];
        int lat;
        logic [31:0] res;
        logic [4:0] t;
        ops = '{3'd4, 3'd6, 3'd5, 3'd7};
        a   = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        b   = '{32'd2, 32'd2, 32'd7, 32'd7};
        exp = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        for (int i = 0; i < 4; i++) begin
            do_op32(ops[i], a[i], b[i], 5'(i + 20), lat, res, t);
            total++;
            if (res !== exp[i] || lat != 33 || t !== 5'(i + 20)) begin
                bad++;
                $display("FAIL div_op%0d result=%h lat=%0d tag=%0d want=%h lat=33 tag=%0d",
                         ops[i], res, lat, t, exp[i], i + 20);
            end
        end
    endtask

    task automatic test_fast();
        logic [2:0]  ops [6];
        logic [31:0] a [6];
        logic [31:0] b [6];
        logic [31:0] exp [6];
        int lat;
        logic [31:0] res;
        logic [4:0] t;
        ops = '{3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd7};
        a   = '{32'h0000ABCD, 32'h00001234, 32'h80000000,
                32'h80000000, 32'd5, 32'h55};
        b   = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
        exp = '{32'hFFFFFFFF, 32'h00001234, 32'h80000000,
                32'h00000000, 32'hFFFFFFFF, 32'h55};
        for (int i = 0; i < 6; i++) begin
            do_op32(ops[i], a[i], b[i], 5'(i + 1), lat, res, t);
            total++;
            if (res !== exp[i] || lat != 1) begin
                bad++;
                $display("FAIL fast_%0d result=%h lat=%0d want=%h lat=1",
                         i, res, lat, exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int held_bad = 0;
        out_ready = 1'b0;
        start32(3'd5, 32'd100, 32'd7, 5'd9);
        wait32(lat);
        total++;
        if (lat != 33) begin
            bad++;
            $display("FAIL bp_latency got=%0d want=33", lat);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_result !== 32'd14 ||
                out_tag !== 5'd9 || in_ready !== 1'b0)
                held_bad++;
        end
        total++;
        if (held_bad != 0) begin
            bad++;
            $display("FAIL bp_hold bad_cycles=%0d want=0 last valid=%b result=%h tag=%0d ready=%b",
                     held_bad, out_valid, out_result, out_tag, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        int lat;
        logic [31:0] res;
        logic [4:0] t;
        flush = 1'b1;
        in_op = 3'd5; in_rs1 = 32'd100; in_rs2 = 32'd7; in_valid = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_blocks_ready got=%b want=0", in_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_blocks_accept busy=%b want=0", busy);
        end
        start32(3'd0, 32'd3, 32'd5, 5'd1);
        repeat (11) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_calc busy=%b valid=%b want 0 0", busy, out_valid);
        end
        do_op32(3'd0, 32'd6, 32'd7, 5'd3, lat, res, t);
        total++;
        if (res !== 32'd42 || t !== 5'd3 || lat != 33) begin
            bad++;
            $display("FAIL flush_next result=%h tag=%0d lat=%0d want=2a tag=3 lat=33",
                     res, t, lat);
        end
    endtask

    task automatic test_async_rst();
        int lat;
        logic [31:0] res;
        logic [4:0] t;
        start32(3'd4, 32'd1000, 32'd3, 5'd2);
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_busy got=%b want=1", busy);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_calc valid=%b busy=%b want 0 0", out_valid, busy);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start32(3'd4, 32'd5, 32'd0, 5'd4);
        wait32(lat);
        #3 rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || lat != 1) begin
            bad++;
            $display("FAIL rst_in_done valid=%b busy=%b lat=%0d want 0 0 lat=1",
                     out_valid, busy, lat);
        end
        #2 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        do_op32(3'd5, 32'd1000, 32'd3, 5'd2, lat, res, t);
        total++;
        if (res !== 32'd333 || lat != 33) begin
            bad++;
            $display("FAIL rst_recover result=%0d lat=%0d want=333 lat=33", res, lat);
        end
    endtask

    task automatic test_xlen16();
        logic [2:0]  ops [6];
        logic [15:0] a [6];
        logic [15:0] b [6];
        logic [15:0] exp [6];
        int lat;
        logic [15:0] res;
        logic [4:0] t;
        ops = '{3'd0, 3'd4, 3'd6, 3'd3, 3'd1, 3'd5};
        a   = '{16'd7, 16'hFFF9, 16'hFFF9, 16'h8000, 16'h8000, 16'd100};
        b   = '{16'hFFFD, 16'd2, 16'd2, 16'hFFFF, 16'hFFFF, 16'd7};
        exp = '{16'hFFEB, 16'hFFFD, 16'hFFFF, 16'h7FFF, 16'h0000, 16'd14};
        for (int i = 0; i < 6; i++) begin
            do_op16(ops[i], a[i], b[i], 5'(i + 7), lat, res, t);
            total++;
            if (res !== exp[i] || lat != 17 || t !== 5'(i + 7)) begin
                bad++;
                $display("FAIL x16_op%0d result=%h lat=%0d tag=%0d want=%h lat=17 tag=%0d",
                         ops[i], res, lat, t, exp[i], i + 7);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_fast();
        test_backpressure();
        test_flush();
        test_async_rst();
        test_xlen16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exu_muldiv.md
Name: exu_muldiv

Overview:
- Multi-cycle RV32M multiply/divide execution unit, the successor to the single-cycle combinational EXU.
- Sits beside the integer EXU and receives decoded M-extension ops with both source operands.
- Produces a write-back result through a valid/ready handshake.
- Data width is parametrised; each op carries an opaque tag (e.g. rd index) that is returned with its result.

Parameters:
XLEN, 32, operand/result width in bits; must be even and >= 8
TAG_W, 5, width of the passthrough tag (destination register index)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset; one clock; reset is asynchronous and active-high
flush  input  1  kill any op in flight, synchronous
in_valid  input  1  op request valid
in_ready  output  1  unit can accept an op
in_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
in_rs1  input  XLEN  source operand 1 (multiplicand / dividend)
in_rs2  input  XLEN  source operand 2 (multiplier / divisor)
in_tag  input  TAG_W  tag, returned unchanged
out_valid  output  1  result valid; also serves as reg_wen
out_ready  input  1  write-back accepts result
out_result  output  XLEN  result
out_tag  output  TAG_W  tag of the op being returned
busy  output  1  state != IDLE

Behaviour:
- FSM states: IDLE, CALC, DONE.
- Reset (async, rst=1): state=IDLE, counter=0, out_valid=0, out_result=0, out_tag=0, busy=0.
- in_ready = (state==IDLE) && !flush. An op is accepted when in_valid && in_ready.
- On accept, latch op, tag and operand magnitudes:
  - Signed operands use the absolute value (two's complement negate if MSB set) per op signedness. MULHSU treats rs1 as signed and rs2 as unsigned.
  - Latch the result sign: product sign = sign1 XOR sign2; quotient sign likewise; remainder sign = dividend sign.
- Fast path, accept cycle -> DONE the next cycle:
  - divide by zero: DIV/DIVU -> all ones; REM/REMU -> rs1.
  - signed overflow (DIV/REM, rs1 = most-negative value, rs2 = -1): DIV -> rs1; REM -> 0.
- Normal path: accept -> CALC; counter loads XLEN; one iteration per cycle; counter decrements.
  - Multiply: shift-add radix-2 into a 2*XLEN accumulator.
  - Divide: restoring radix-2 on an XLEN-bit partial remainder.
- When counter reaches 0: apply sign correction (negate if the latched sign is set), select the field, go to DONE.
  - MUL takes the low XLEN bits of the product; MULH* take the high XLEN bits.
- Latency: out_valid rises exactly XLEN+1 cycles after the accept edge on the normal path, and 1 cycle after it on the fast path.
- DONE: out_valid=1; out_result and out_tag are stable while out_valid && !out_ready.
  - When out_ready=1: state -> IDLE and out_valid -> 0 the next cycle.
  - No back-to-back accept: in_ready returns one cycle after the output handshake.
- flush=1 in any state: next state IDLE, out_valid=0, counter cleared, no result emitted.
  - flush overrides a same-cycle output handshake; that result is discarded.
  - flush blocks a same-cycle accept.
- in_* inputs are ignored outside the accept cycle; operands may change freely during CALC.
- rst asserted mid-CALC or in DONE aborts immediately; no output.
- All arithmetic is modulo 2^XLEN, matching the RISC-V M spec bit-exactly, including the most-negative operand for MULH/MULHSU.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD), tag=5, out_ready=1 -> out_valid exactly 33 cycles after accept, out_result=0xFFFFFFEB, out_tag=5, then IDLE.
- MULH/MULHSU/MULHU with rs1=0x80000000, rs2=0xFFFFFFFF:
  - MULH -> 0x00000000; MULHSU -> 0x80000000; MULHU -> 0x7FFFFFFF.
- DIV rs1=-7, rs2=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU rs1=100, rs2=7 -> 14; REMU -> 2.
- Fast paths, each with out_valid 1 cycle after accept:
  - DIVU x/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234.
  - DIV 0x80000000/-1 -> 0x80000000; REM same -> 0.
- Backpressure and flush:
  - out_ready=0 for 10 cycles in DONE -> out_valid, out_result and out_tag held constant; in_ready stays 0.
  - flush on cycle 12 of CALC -> IDLE next cycle, no out_valid, a new op is accepted the following cycle and returns a correct result.
- Async rst pulse mid-CALC (between edges) -> out_valid=0 and busy=0 immediately, before the next clk edge.
- Rerun MUL/DIV cases with XLEN=16 -> out_valid at cycle 17, results correct modulo 2^16.
